axis_pkt_fifo: RTL and testbench

Single-clock AXI4-Stream FIFO with registered sink and source ports, stored TKEEP/TLAST and an optional store-and-forward packet mode. It is the generalised successor of the stream-sink-to-FIFO block. It takes any stream width and depth, forwards a full AXIS stream instead of a raw FIFO read port, reports occupancy and can drop overflowing packets whole. It sits between a DMA/AXIS producer and any AXIS consumer in the same clock domain.

---
 rtl/axis_pkt_fifo_pkg.sv | 33 +++
 rtl/axis_pkt_fifo_ram.sv | 44 ++++
 rtl/axis_pkt_fifo.sv | 257 +++++++++++++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo_pkg
// Shared definitions for the axis_pkt_fifo block:
//   - ingress FSM state encoding (used only when AXIS_PKT_FIFO_PACKET_MODE_EN
//     is defined)
//   - clogb2(): ceil(log2(value)), used to size pointers and counters
//   - mem_word_width(): width of one stored word {TLAST, TKEEP, TDATA}
// -----------------------------------------------------------------------------
package axis_pkt_fifo_pkg;

    typedef enum logic {
        ING_ACCEPT = 1'b0,
        ING_DROP   = 1'b1
    } ing_state_t;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int mem_word_width(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

    // Stored word width for the default 32-bit stream: 32 data + 4 keep + 1 last.
    localparam int DEFAULT_TDATA_WIDTH = 32;
    localparam int DEFAULT_MEM_WIDTH   = mem_word_width(DEFAULT_TDATA_WIDTH);

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo_ram
// Simple dual-port RAM with one write port and one registered read port.
// Written in the plain inference template so block RAM is picked up by
// common synthesis tools. rd_data holds its value while rd_en is low,
// which the FIFO relies on while its output stage is stalled.
//
// Ports:
//   clk      in   clock for both ports
//   wr_en    in   write strobe
//   wr_addr  in   write address (AW bits)
//   wr_data  in   write data (W bits)
//   rd_en    in   read strobe; rd_data updates on the next rising edge
//   rd_addr  in   read address (AW bits)
//   rd_data  out  registered read data (W bits)
// -----------------------------------------------------------------------------
module axis_pkt_fifo_ram #(
    parameter int W  = 37,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
// Single-clock AXI4-Stream FIFO. Stores {TLAST, TKEEP, TDATA} per word in a
// synchronous-read RAM followed by a one-word output register. Capacity is
// exactly FIFO_DEPTH words, counting the RAM read stage and output register.
//
// Build option: macro AXIS_PKT_FIFO_PACKET_MODE_EN
//   defined   - store-and-forward: a packet becomes visible to the read side
//               only after its TLAST beat is stored; packets that do not fit
//               are dropped whole; the sink is never backpressured.
//   undefined - cut-through FIFO with backpressure; pkt_count and
//               drop_pulse are tied to 0.
//
// Ingress FSM (packet mode only):
//   state      | meaning
//   ING_ACCEPT | beats are stored; a beat arriving while full starts a drop
//   ING_DROP   | beats discarded until TLAST, then the partial packet is rolled back
//
// Ports:
//   S_AXIS_ACLK   in   clock
//   rst           in   asynchronous active-high reset
//   S_AXIS_*      sink   TVALID/TREADY/TDATA/TKEEP/TLAST
//   M_AXIS_*      source TVALID/TREADY/TDATA/TKEEP/TLAST
//   data_count    out  words held, including uncommitted packet words
//   pkt_count     out  committed packets not yet fully popped
//   drop_pulse    out  one-cycle pulse after a packet is discarded
// -----------------------------------------------------------------------------
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter  int C_AXIS_TDATA_WIDTH = 32,
    parameter  int FIFO_DEPTH         = 1024,
    localparam int CW                 = clogb2(FIFO_DEPTH) + 1
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            rst,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                            S_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                            M_AXIS_TLAST,
    output logic [CW-1:0]                   data_count,
    output logic [CW-1:0]                   pkt_count,
    output logic                            drop_pulse
);

    localparam int AW = clogb2(FIFO_DEPTH);
    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int KW = C_AXIS_TDATA_WIDTH / 8;
    localparam int MW = mem_word_width(C_AXIS_TDATA_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic          ready_en;
    logic          full;
    logic          push;
    logic          push_store;
    logic          pop;
    logic          move;
    logic          rd_issue;
    logic [CW-1:0] data_count_q;
    logic [CW-1:0] rd_avail_q;
    logic [CW-1:0] avail_add;
    logic [CW-1:0] drop_sub;
    logic [AW-1:0] wr_ptr_spec;
    logic [AW-1:0] rd_ptr;
    logic          rd_valid_q;
    logic          out_valid_q;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] ram_dout;
    logic [MW-1:0] out_q;

    assign full     = (data_count_q == DEPTH_C);
    assign push     = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop      = out_valid_q && M_AXIS_TREADY;
    // RAM read data moves into the output register when that register is
    // empty or being emptied this cycle.
    assign move     = rd_valid_q && (!out_valid_q || pop);
    // rd_avail_q counts words written and visible to the read side but not
    // yet read out of the RAM.
    assign rd_issue = (rd_avail_q != '0) && (!rd_valid_q || move);
    assign wr_word  = {S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA};

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN

    ing_state_t    state_q;
    ing_state_t    state_d;
    logic          discard;
    logic          commit;
    logic          drop_now;
    logic          pop_last;
    logic [AW-1:0] wr_ptr_commit;
    logic [CW-1:0] uncommit_q;
    logic [CW-1:0] pkt_count_q;
    logic          drop_pulse_q;

    assign S_AXIS_TREADY = ready_en;
    assign pop_last      = pop && out_q[MW-1];

    always_ff @(posedge S_AXIS_ACLK or posedge rst) begin
        if (rst) begin
            state_q <= ING_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // A single TLAST beat arriving while full never enters ING_DROP; it is
    // rolled back on the spot by drop_now.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ING_ACCEPT: if (push && full && !S_AXIS_TLAST) state_d = ING_DROP;
            ING_DROP:   if (push && S_AXIS_TLAST)          state_d = ING_ACCEPT;
            default:    state_d = ING_ACCEPT;
        endcase
    end

    always_comb begin
        push_store = 1'b0;
        discard    = 1'b0;
        case (state_q)
            ING_ACCEPT: begin
                push_store = push && !full;
                discard    = push && full;
            end
            ING_DROP: begin
                discard    = push;
            end
            default: ;
        endcase
        commit    = push_store && S_AXIS_TLAST;
        drop_now  = discard && S_AXIS_TLAST;
        avail_add = commit   ? (uncommit_q + CW'(1)) : '0;
        drop_sub  = drop_now ? uncommit_q            : '0;
    end

    always_ff @(posedge S_AXIS_ACLK or posedge rst) begin
        if (rst) begin
            wr_ptr_spec   <= '0;
            wr_ptr_commit <= '0;
            uncommit_q    <= '0;
            pkt_count_q   <= '0;
            drop_pulse_q  <= 1'b0;
        end else begin
            drop_pulse_q <= drop_now;
            if (drop_now) begin
                wr_ptr_spec <= wr_ptr_commit;
                uncommit_q  <= '0;
            end else if (push_store) begin
                wr_ptr_spec <= wr_ptr_spec + AW'(1);
                if (commit) begin
                    wr_ptr_commit <= wr_ptr_spec + AW'(1);
                    uncommit_q    <= '0;
                end else begin
                    uncommit_q    <= uncommit_q + CW'(1);
                end
            end
            case ({commit, pop_last})
                2'b10:   pkt_count_q <= pkt_count_q + CW'(1);
                2'b01:   pkt_count_q <= pkt_count_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_pulse = drop_pulse_q;

`else

    // Ready depends only on registered state, never on M_AXIS_TREADY.
    assign S_AXIS_TREADY = ready_en && !full;
    assign push_store    = push;
    assign avail_add     = CW'(push_store);
    assign drop_sub      = '0;

    always_ff @(posedge S_AXIS_ACLK or posedge rst) begin
        if (rst) begin
            wr_ptr_spec <= '0;
        end else if (push_store) begin
            wr_ptr_spec <= wr_ptr_spec + AW'(1);
        end
    end

    assign pkt_count  = '0;
    assign drop_pulse = 1'b0;

`endif

    // Holds the sink closed until the first edge after reset release.
    always_ff @(posedge S_AXIS_ACLK or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge rst) begin
        if (rst) begin
            data_count_q <= '0;
            rd_avail_q   <= '0;
            rd_ptr       <= '0;
        end else begin
            data_count_q <= data_count_q + CW'(push_store) - CW'(pop) - drop_sub;
            rd_avail_q   <= rd_avail_q + avail_add - CW'(rd_issue);
            if (rd_issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge rst) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (rd_issue) begin
                rd_valid_q <= 1'b1;
            end else if (move) begin
                rd_valid_q <= 1'b0;
            end
            if (move) begin
                out_q       <= ram_dout;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    axis_pkt_fifo_ram #(
        .W  (MW),
        .AW (AW)
    ) u_ram (
        .clk     (S_AXIS_ACLK),
        .wr_en   (push_store),
        .wr_addr (wr_ptr_spec),
        .wr_data (wr_word),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_dout)
    );

    assign M_AXIS_TVALID = out_valid_q;
    assign M_AXIS_TDATA  = out_q[DW-1:0];
    assign M_AXIS_TKEEP  = out_q[DW+KW-1:DW];
    assign M_AXIS_TLAST  = out_q[MW-1];
    assign data_count    = data_count_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
module tb_axis_pkt_fifo;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          S_AXIS_ACLK = 1'b0;
    logic          rst;
    logic          S_AXIS_TVALID;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] S_AXIS_TDATA;
    logic [KW-1:0] S_AXIS_TKEEP;
    logic          S_AXIS_TLAST;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic [KW-1:0] M_AXIS_TKEEP;
    logic          M_AXIS_TLAST;
    logic [CW-1:0] data_count;
    logic [CW-1:0] pkt_count;
    logic          drop_pulse;

    axis_pkt_fifo #(
        .C_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .S_AXIS_ACLK   (S_AXIS_ACLK),
        .rst           (rst),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .data_count    (data_count),
        .pkt_count     (pkt_count),
        .drop_pulse    (drop_pulse)
    );

    always #5 S_AXIS_ACLK = ~S_AXIS_ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge S_AXIS_ACLK) cyc <= cyc + 1;

    // Scoreboard / reference model, sampled on the falling edge
    logic [36:0] exp_q[$];
    logic [36:0] mon_word;
    logic [36:0] prev_word;
    bit          sb_en = 1'b0;
    bit          prev_stall = 1'b0;
    int          mcnt = 0;
    int          mpkt = 0;
    int          sb_pops = 0;
    int          peak = 0;
    int          drop_seen = 0;
    int          drop_cyc = -1;
    int          first_valid_cyc = -1;

    always @(negedge S_AXIS_ACLK) begin
        mon_word = {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA};
        if (!rst && drop_pulse) begin
            drop_seen++;
            drop_cyc = cyc;
        end
        if (!rst && M_AXIS_TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (sb_en) begin
            chk("data_count", data_count, mcnt);
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
            chk("pkt_count", pkt_count, mpkt);
`endif
            if (int'(data_count) > peak) peak = int'(data_count);
            if (prev_stall) begin
                chk("hold_valid", M_AXIS_TVALID, 1);
                chk("hold_word", mon_word, prev_word);
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                exp_q.push_back({S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA});
                mcnt++;
                if (S_AXIS_TLAST) mpkt++;
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("sb_word", mon_word, exp_q.pop_front());
                mcnt--;
                if (M_AXIS_TLAST) mpkt--;
                sb_pops++;
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_word  = mon_word;
        end
    end

    task automatic model_reset();
        exp_q.delete();
        mcnt       = 0;
        mpkt       = 0;
        prev_stall = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge S_AXIS_ACLK);
        #1;
    endtask

    task automatic idle_sink();
        S_AXIS_TVALID = 1'b0;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             output int push_edge);
        int  waited;
        bit  done;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TKEEP  = k;
        S_AXIS_TLAST  = l;
        waited = 0;
        done   = 1'b0;
        push_edge = -1;
        while (!done) begin
            @(negedge S_AXIS_ACLK);
            if (S_AXIS_TREADY) begin
                @(posedge S_AXIS_ACLK);
                #1;
                push_edge = cyc;
                done = 1'b1;
            end else if (waited >= 500) begin
                chk("send_timeout", S_AXIS_TREADY, 1);
                done = 1'b1;
            end else begin
                waited++;
            end
        end
    endtask

    task automatic wait_drain(input int maxc);
        int k;
        k = 0;
        while ((data_count != 0 || M_AXIS_TVALID) && k < maxc) begin
            tick(1);
            k++;
        end
        chk("drain_count", data_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: stuck at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    int  e, first_push, last_push, accepted, got;
    bit  late_ready;
    bit  rnd_done;

    initial begin
        rst = 1'b1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        model_reset();
        tick(3);

        // Reset values
        chk("rst_s_ready", S_AXIS_TREADY, 0);
        chk("rst_m_valid", M_AXIS_TVALID, 0);
        chk("rst_tdata",   M_AXIS_TDATA, 0);
        chk("rst_tkeep",   M_AXIS_TKEEP, 0);
        chk("rst_tlast",   M_AXIS_TLAST, 0);
        chk("rst_count",   data_count, 0);
        chk("rst_pkt",     pkt_count, 0);
        chk("rst_drop",    drop_pulse, 0);
        rst = 1'b0;
        @(negedge S_AXIS_ACLK);
        chk("first_edge_ready", S_AXIS_TREADY, 0);
        tick(1);
        chk("ready_after_release", S_AXIS_TREADY, 1);

        // 16-word stream 0..15, consumer always ready
        sb_en = 1'b1;
        sb_pops = 0;
        peak = 0;
        first_valid_cyc = -1;
        M_AXIS_TREADY = 1'b1;
        first_push = -1;
        last_push = -1;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'(i), 4'hF, i == 15, e);
            if (i == 0) first_push = e;
            last_push = e;
        end
        idle_sink();
        wait_drain(100);
        chk("stream_popped", sb_pops, 16);
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
        chk("pk_latency", first_valid_cyc - last_push, 2);
`else
        chk("ct_latency", first_valid_cyc - first_push, 2);
        chk("ct_peak_le3", peak <= 3, 1);
        chk("ct_pkt_zero", pkt_count, 0);
`endif

`ifndef AXIS_PKT_FIFO_PACKET_MODE_EN
        // Fill to capacity with consumer stalled
        sb_pops = 0;
        M_AXIS_TREADY = 1'b0;
        accepted = 0;
        late_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = 32'(100 + i);
            S_AXIS_TKEEP  = 4'hF;
            S_AXIS_TLAST  = (i == 19);
            @(negedge S_AXIS_ACLK);
            if (S_AXIS_TREADY) begin
                if (accepted >= 16) late_ready = 1'b1;
                accepted++;
            end
            tick(1);
        end
        idle_sink();
        chk("full_accepted", accepted, 16);
        chk("full_ready_held_low", late_ready, 0);
        chk("full_count", data_count, 16);
        chk("full_ready", S_AXIS_TREADY, 0);
        M_AXIS_TREADY = 1'b1;
        tick(1);
        M_AXIS_TREADY = 1'b0;
        chk("pop_reopens_ready", S_AXIS_TREADY, 1);
        chk("pop_count", data_count, 15);
        M_AXIS_TREADY = 1'b1;
        wait_drain(100);
        chk("full_popped", sb_pops, 16);
`endif

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
        // 8-beat packet: nothing visible until TLAST is stored
        sb_pops = 0;
        first_valid_cyc = -1;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(32'h200 + 32'(i), 4'hF, i == 7, e);
            last_push = e;
        end
        idle_sink();
        chk("pk8_commit_cnt", pkt_count, 1);
        chk("pk8_not_visible", M_AXIS_TVALID, 0);
        wait_drain(100);
        chk("pk8_latency", first_valid_cyc - last_push, 2);
        chk("pk8_pkt_zero", pkt_count, 0);
        chk("pk8_popped", sb_pops, 8);

        // Second packet does not fit behind a stalled 10-word packet
        sb_en = 1'b0;
        model_reset();
        M_AXIS_TREADY = 1'b0;
        drop_seen = 0;
        drop_cyc = -1;
        for (int i = 0; i < 10; i++) send_beat(32'h300 + 32'(i), 4'hF, i == 9, e);
        for (int i = 0; i < 10; i++) begin
            send_beat(32'h400 + 32'(i), 4'hF, i == 9, e);
            last_push = e;
        end
        idle_sink();
        tick(2);
        chk("drop_once", drop_seen, 1);
        chk("drop_timing", drop_cyc, last_push);
        chk("drop_count", data_count, 10);
        chk("drop_pkt", pkt_count, 1);
        M_AXIS_TREADY = 1'b1;
        got = 0;
        repeat (40) begin
            @(negedge S_AXIS_ACLK);
            if (M_AXIS_TVALID) begin
                chk("drop_out_data", M_AXIS_TDATA, 32'h300 + 32'(got));
                chk("drop_out_last", M_AXIS_TLAST, got == 9);
                got++;
            end
        end
        tick(1);
        chk("drop_out_words", got, 10);
        chk("drop_empty", data_count, 0);
        chk("drop_pkt_zero", pkt_count, 0);
        model_reset();
        sb_en = 1'b1;
`endif

        // Random handshakes on both sides
        model_reset();
        sb_pops = 0;
        rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    M_AXIS_TREADY = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
                    if (i % 4 == 0) begin
                        int g;
                        g = 0;
                        idle_sink();
                        while (mcnt > DEPTH - 4 && g < 500) begin
                            tick(1);
                            g++;
                        end
                    end
`endif
                    if ($urandom_range(0, 1) == 1) begin
                        idle_sink();
                        tick(1);
                    end
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
                    send_beat($urandom, 4'($urandom_range(0, 15)), (i % 4) == 3, e);
`else
                    send_beat($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0, e);
`endif
                end
                idle_sink();
                wait_drain(5000);
                rnd_done = 1'b1;
            end
        join
        M_AXIS_TREADY = 1'b0;
        chk("rnd_popped", sb_pops, 1000);
        chk("rnd_queue_empty", exp_q.size(), 0);
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
        chk("rnd_no_drop", drop_seen, 0);
`endif

        // Reset in the middle of a packet
        tick(1);
        model_reset();
        for (int i = 0; i < 7; i++) send_beat(32'h500 + 32'(i), 4'hF, 1'b0, e);
        idle_sink();
        chk("mid_count", data_count, 7);
        sb_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", M_AXIS_TVALID, 0);
        chk("mid_rst_count", data_count, 0);
        chk("mid_rst_ready", S_AXIS_TREADY, 0);
        chk("mid_rst_tdata", M_AXIS_TDATA, 0);
        chk("mid_rst_pkt", pkt_count, 0);
        tick(1);
        rst = 1'b0;
        model_reset();
        tick(1);
        sb_en = 1'b1;
        sb_pops = 0;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(32'h600 + 32'(i), 4'h3, i == 4, e);
        idle_sink();
        wait_drain(100);
        chk("post_rst_popped", sb_pops, 5);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
